// File: rtl/fifo_uart_pkg.sv
// fifo_uart_pkg
//   Shared definitions for the FIFO-to-UART drain stage.
//   - txState_t   : FSM state encoding (IDLE, REQ, LOAD, START, DATA, PARITY, STOP)
//   - TX_IDLE_LVL : level of the serial line when nothing is being sent
//   - clog2       : ceiling log2, used to size counters from parameters
package fifo_uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    PARITY = 3'd5,
    STOP   = 3'd6
  } txState_t;

  localparam logic TX_IDLE_LVL = 1'b1;

  // Number of bits needed to hold values 0..value-1 (0 for value <= 1).
  function automatic int clog2(input int value);
    int width;
    width = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      width++;
    end
    return width;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer
//   Bit-period timer for the UART transmitter. Counts 0..CLKS_PER_BIT-1 while
//   running and wraps, so a run of consecutive bits is timed back to back.
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous, active-high reset
//   clear_i    in   synchronous clear (held while the FSM is outside a bit state)
//   run_i      in   1 = count
//   tick_o     out  one-cycle pulse in the last cycle of a bit period
//   preTick_o  out  one-cycle pulse one cycle before tick_o, lets the owner
//                   register outputs that must coincide with tick_o
import fifo_uart_pkg::*;

module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic run_i,
  output logic tick_o,
  output logic preTick_o
);

  localparam int CntW = (clog2(CLKS_PER_BIT) < 1) ? 1 : clog2(CLKS_PER_BIT);
  // Wrap point is CLKS_PER_BIT-1, not the natural 2^CntW overflow.
  localparam logic [CntW-1:0] LastCnt = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] PreCnt  = CntW'(CLKS_PER_BIT - 2);

  logic [CntW-1:0] count_q;
  logic [CntW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (run_i) begin
      count_d = (count_q == LastCnt) ? '0 : count_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tick_o    = run_i && (count_q == LastCnt);
  assign preTick_o = run_i && (count_q == PreCnt);

endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx
//   Drain stage for a small FIFO: pops one word at a time while the FIFO is
//   non-empty and sends it as an asynchronous serial frame on tx
//   (start bit, DATA_W data bits LSB first, optional parity, stop bit(s)).
// Configuration
//   FIFO_UART_TX_PARITY_EN : when defined, an even-parity bit follows the data.
// Ports
//   clk         in   clock, rising edge
//   rst         in   synchronous, active-high reset
//   enable      in   1 = allowed to start new frames
//   fifo_empty  in   FIFO empty flag
//   fifo_dout   in   FIFO read data, valid the cycle after fifo_rd
//   fifo_rd     out  one-cycle pop request
//   tx          out  serial line, idle high
//   busy        out  1 from REQ through the last stop-bit cycle
//   frame_done  out  one-cycle pulse in the final cycle of the final stop bit
import fifo_uart_pkg::*;

module fifo_uart_tx #(
  parameter int DATA_W       = 4,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              fifo_rd,
  output logic              tx,
  output logic              busy,
  output logic              frame_done
);

  localparam int IdxW = (clog2(DATA_W) < 1) ? 1 : clog2(DATA_W);
  localparam logic [IdxW-1:0] LastIdx  = IdxW'(DATA_W - 1);
  localparam logic            LastStop = 1'(STOP_BITS - 1);

  txState_t          state_q;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] shiftNext;
  logic [IdxW-1:0]   bitIdx_q;
  logic              stopCnt_q;
  logic              tx_q;
  logic              fifoRd_q;
  logic              busy_q;
  logic              frameDone_q;
`ifdef FIFO_UART_TX_PARITY_EN
  logic              parity_q;
`endif

  logic timerRun;
  logic tick;
  logic preTick;
  logic startNext;

  assign timerRun  = (state_q == START) || (state_q == DATA) ||
                     (state_q == PARITY) || (state_q == STOP);
  assign startNext = enable && !fifo_empty;
  assign shiftNext = shift_q >> 1;

  // The timer is held at zero outside the bit states, so it always starts a
  // frame at count 0; between bits it wraps on its own.
  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (!timerRun),
    .run_i    (timerRun),
    .tick_o   (tick),
    .preTick_o(preTick)
  );

  // Outputs are registered alongside the state, so every output is updated
  // on the same edge that enters the state it belongs to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      tx_q        <= TX_IDLE_LVL;
      fifoRd_q    <= 1'b0;
      busy_q      <= 1'b0;
      frameDone_q <= 1'b0;
      shift_q     <= '0;
      bitIdx_q    <= '0;
      stopCnt_q   <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      fifoRd_q    <= 1'b0;
      frameDone_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (startNext) begin
            state_q  <= REQ;
            fifoRd_q <= 1'b1;
            busy_q   <= 1'b1;
          end
        end
        REQ: begin
          state_q <= LOAD;
        end
        LOAD: begin
          shift_q <= fifo_dout;
`ifdef FIFO_UART_TX_PARITY_EN
          parity_q <= ^fifo_dout;
`endif
          state_q <= START;
          tx_q    <= 1'b0;
        end
        START: begin
          if (tick) begin
            state_q  <= DATA;
            tx_q     <= shift_q[0];
            bitIdx_q <= '0;
          end
        end
        DATA: begin
          if (tick) begin
            if (bitIdx_q == LastIdx) begin
`ifdef FIFO_UART_TX_PARITY_EN
              state_q   <= PARITY;
              tx_q      <= parity_q;
`else
              state_q   <= STOP;
              tx_q      <= TX_IDLE_LVL;
              stopCnt_q <= 1'b0;
`endif
            end else begin
              bitIdx_q <= bitIdx_q + IdxW'(1);
              shift_q  <= shiftNext;
              tx_q     <= shiftNext[0];
            end
          end
        end
`ifdef FIFO_UART_TX_PARITY_EN
        PARITY: begin
          if (tick) begin
            state_q   <= STOP;
            tx_q      <= TX_IDLE_LVL;
            stopCnt_q <= 1'b0;
          end
        end
`endif
        STOP: begin
          // preTick lands one cycle early so the registered pulse lines up
          // with the final cycle of the final stop bit.
          if (preTick && (stopCnt_q == LastStop)) begin
            frameDone_q <= 1'b1;
          end
          if (tick) begin
            if (stopCnt_q != LastStop) begin
              stopCnt_q <= stopCnt_q + 1'b1;
            end else if (startNext) begin
              state_q  <= REQ;
              fifoRd_q <= 1'b1;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= TX_IDLE_LVL;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign fifo_rd    = fifoRd_q;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = frameDone_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx
//   Self-checking bench for fifo_uart_tx (DATA_W=4, CLKS_PER_BIT=4, STOP_BITS=1).
//   A queue-based FIFO model feeds the DUT; each frame is captured as a per-cycle
//   bit vector and compared with a frame built from the word's bits.
//   Honours FIFO_UART_TX_PARITY_EN for the expected frame layout.
module tb_fifo_uart_tx;

  localparam int DATA_W    = 4;
  localparam int CPB       = 4;
  localparam int STOP_BITS = 1;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FRAME_LEN = (1 + DATA_W + PAR + STOP_BITS) * CPB;

  typedef struct {
    logic [3:0] word;
    logic       expParity;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       fifo_empty = 1'b1;
  logic [3:0] fifo_dout = 4'h0;
  logic       fifo_rd;
  logic       tx;
  logic       busy;
  logic       frame_done;

  logic       pushEn = 1'b0;
  logic [3:0] pushData = 4'h0;
  logic [3:0] fifoQ[$];
  int         rdEmptyCount = 0;
  int         rdPulses = 0;

  int checks = 0;
  int fails = 0;

  fifo_uart_tx #(
    .DATA_W      (DATA_W),
    .CLKS_PER_BIT(CPB),
    .STOP_BITS   (STOP_BITS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .fifo_empty(fifo_empty),
    .fifo_dout (fifo_dout),
    .fifo_rd   (fifo_rd),
    .tx        (tx),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // FIFO model: registered dout one cycle after rd, registered empty flag.
  always @(posedge clk) begin
    if (fifo_rd === 1'b1) begin
      if (fifoQ.size() == 0) rdEmptyCount++;
      else fifo_dout <= fifoQ.pop_front();
    end
    if (pushEn) fifoQ.push_back(pushData);
    fifo_empty <= (fifoQ.size() == 0);
  end

  always @(negedge clk) begin
    if (fifo_rd === 1'b1) rdPulses++;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, actual, expected);
    end
  endtask

  // Push one word into the FIFO model; returns at the next falling edge.
  task automatic applyStimulus(input logic [3:0] w);
    pushData = w;
    pushEn   = 1'b1;
    @(negedge clk);
    pushEn   = 1'b0;
  endtask

  function automatic logic parityOf(input logic [3:0] w);
    int ones;
    ones = 0;
    for (int i = 0; i < 4; i++) ones += int'(w[i]);
    return 1'(ones % 2);
  endfunction

  // Expected tx level per clock of one frame, cycle 0 in bit 0.
  function automatic logic [31:0] expTx(input logic [3:0] w, input logic p);
    logic [31:0] v;
    logic [7:0]  bits;
    int          n;
    v    = '0;
    bits = '0;
    n    = 0;
    bits[n] = 1'b0; n++;
    for (int i = 0; i < DATA_W; i++) begin
      bits[n] = w[i]; n++;
    end
    if (PAR != 0) begin
      bits[n] = p; n++;
    end
    for (int s = 0; s < STOP_BITS; s++) begin
      bits[n] = 1'b1; n++;
    end
    for (int b = 0; b < n; b++)
      for (int c = 0; c < CPB; c++) v[b*CPB + c] = bits[b];
    return v;
  endfunction

  task automatic waitStart(input string name);
    int n;
    n = 0;
    while (tx !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (tx !== 1'b0) checkOutput({name, " start timeout"}, 32'(tx), 32'd0);
  endtask

  task automatic measureGap(output int gap);
    gap = 0;
    @(negedge clk);
    while (tx === 1'b1 && gap < 50) begin
      gap++;
      @(negedge clk);
    end
  endtask

  // Starts sampling at the current falling edge (first start-bit cycle).
  task automatic checkFrame(input string name, input logic [3:0] w,
                            input logic p, input int dropAt);
    logic [31:0] txV, doneV, busyV;
    txV = '0; doneV = '0; busyV = '0;
    for (int c = 0; c < FRAME_LEN; c++) begin
      if (c > 0) @(negedge clk);
      if (c == dropAt) enable = 1'b0;
      txV[c]   = tx;
      doneV[c] = frame_done;
      busyV[c] = busy;
    end
    checkOutput({name, " tx"}, txV, expTx(w, p));
    checkOutput({name, " frame_done"}, doneV, 32'd1 << (FRAME_LEN - 1));
    checkOutput({name, " busy"}, busyV, (32'd1 << FRAME_LEN) - 32'd1);
  endtask

  initial begin
    vec_t        vecs[8];
    logic [3:0]  expQ[$];
    logic [3:0]  w;
    logic [31:0] rdV, txV, busyV;
    int          rdBase, gap, lows, k;

    vecs = '{'{4'hA, 1'b0}, '{4'h3, 1'b0}, '{4'hC, 1'b0}, '{4'h7, 1'b1},
             '{4'h5, 1'b0}, '{4'hF, 1'b0}, '{4'h1, 1'b1}, '{4'hE, 1'b1}};

    // Reset held with a word waiting in the FIFO.
    rst = 1'b1;
    enable = 1'b1;
    @(negedge clk);
    applyStimulus(4'hA);
    for (int c = 0; c < 3; c++) begin
      checkOutput($sformatf("reset cycle %0d", c),
                  {28'b0, tx, fifo_rd, busy, frame_done}, 32'h8);
      if (c < 2) @(negedge clk);
    end

    // Single word after reset release.
    rdBase = rdPulses;
    rst = 1'b0;
    waitStart("single");
    checkFrame("single 4'hA", 4'hA, 1'b0, -1);
    repeat (4) @(negedge clk);
    checkOutput("single rd pulses", 32'(rdPulses - rdBase), 32'd1);
    checkOutput("single idle", {30'b0, tx, busy}, 32'h2);
    checkOutput("single fifo left", 32'(fifoQ.size()), 32'd0);

    // Latency: empty falls at N, rd at N+1, tx falls at N+3.
    applyStimulus(4'h6);
    rdV = '0; txV = '0; busyV = '0;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge clk);
      rdV[c] = fifo_rd; txV[c] = tx; busyV[c] = busy;
    end
    checkOutput("latency fifo_rd", rdV, 32'b0010);
    checkOutput("latency tx", txV, 32'b0111);
    checkOutput("latency busy", busyV, 32'b1110);
    checkFrame("latency 4'h6", 4'h6, 1'b0, -1);

    // Back-to-back, first holding off with enable low.
    enable = 1'b0;
    repeat (2) @(negedge clk);
    rdBase = rdPulses;
    applyStimulus(4'h3);
    applyStimulus(4'hC);
    repeat (8) @(negedge clk);
    checkOutput("disabled no pop", 32'(rdPulses - rdBase), 32'd0);
    checkOutput("disabled idle", {30'b0, tx, busy}, 32'h2);
    enable = 1'b1;
    waitStart("b2b");
    checkFrame("b2b 4'h3", 4'h3, 1'b0, -1);
    measureGap(gap);
    checkOutput("b2b gap", 32'(gap), 32'd2);
    checkFrame("b2b 4'hC", 4'hC, 1'b0, -1);
    repeat (4) @(negedge clk);
    checkOutput("b2b fifo left", 32'(fifoQ.size()), 32'd0);
    checkOutput("b2b rd pulses", 32'(rdPulses - rdBase), 32'd2);

    // Enable dropped during the first frame's data bits.
    enable = 1'b0;
    rdBase = rdPulses;
    applyStimulus(4'h9);
    applyStimulus(4'h4);
    enable = 1'b1;
    waitStart("gate");
    checkFrame("gate 4'h9", 4'h9, 1'b0, CPB + 1);
    lows = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    checkOutput("gate tx low cycles", 32'(lows), 32'd0);
    checkOutput("gate busy", 32'(busy), 32'd0);
    checkOutput("gate fifo left", 32'(fifoQ.size()), 32'd1);
    checkOutput("gate rd pulses", 32'(rdPulses - rdBase), 32'd1);
    enable = 1'b1;
    waitStart("gate resume");
    checkFrame("gate 4'h4", 4'h4, 1'b1, -1);

    // Reset in the middle of data bit 2.
    enable = 1'b0;
    applyStimulus(4'h3);
    applyStimulus(4'h5);
    enable = 1'b1;
    waitStart("rst mid");
    repeat (3*CPB + 1) @(negedge clk);
    checkOutput("rst mid data bit2", 32'(tx), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst mid response", {28'b0, tx, busy, fifo_rd, frame_done}, 32'h8);
    rst = 1'b0;
    waitStart("after rst");
    checkFrame("after rst 4'h5", 4'h5, 1'b0, -1);
    repeat (3) @(negedge clk);
    checkOutput("after rst fifo left", 32'(fifoQ.size()), 32'd0);

    // Table of single words.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].word);
      waitStart($sformatf("table[%0d]", i));
      checkFrame($sformatf("table[%0d] 0x%h", i, vecs[i].word),
                 vecs[i].word, vecs[i].expParity, -1);
    end

    // Random bursts of 1..3 words; later words arrive mid-frame.
    for (int it = 0; it < 8; it++) begin
      repeat (3) @(negedge clk);
      k = $urandom_range(1, 3);
      for (int j = 0; j < k; j++) begin
        w = 4'($urandom);
        expQ.push_back(w);
        applyStimulus(w);
      end
      for (int j = 0; j < k; j++) begin
        if (j == 0) begin
          waitStart($sformatf("rand[%0d]", it));
        end else begin
          measureGap(gap);
          checkOutput($sformatf("rand[%0d.%0d] gap", it, j), 32'(gap), 32'd2);
        end
        w = expQ.pop_front();
        checkFrame($sformatf("rand[%0d.%0d] 0x%h", it, j, w), w, parityOf(w), -1);
      end
    end

    repeat (4) @(negedge clk);
    checkOutput("final fifo left", 32'(fifoQ.size()), 32'd0);
    checkOutput("rd while empty", 32'(rdEmptyCount), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
